// File: rtl/bf_result_streamer.sv
// rtl/bf_result_streamer.sv - streams Bellman-Ford output distances with checksum and unreachable count
module bf_result_streamer #(
  parameter int                 ADDR_W    = 13,
  parameter int                 DATA_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  INF       = '1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_done,
  input  logic              i_neg_cycle,
  input  logic [ADDR_W-1:0] i_node_count,
  output logic [ADDR_W-1:0] o_omar,
  input  logic [DATA_W-1:0] i_omdr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_out_last,
  output logic [23:0]       o_sum,
  output logic [ADDR_W-1:0] o_inf_count,
  output logic              o_busy,
  output logic              o_finished
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    NEG   = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] MARKER = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_index;
  logic              r_valid;
  logic              r_last;
  logic [23:0]       r_sum;
  logic [ADDR_W-1:0] r_inf;
  logic              r_busy;
  logic              r_finished;
  logic [ADDR_W-1:0] w_omar;
  logic [ADDR_W-1:0] w_idx_p1;
  logic [ADDR_W-1:0] w_idx_p2;

  assign w_idx_p1 = r_idx + ADDR_W'(1);
  assign w_idx_p2 = r_idx + ADDR_W'(2);

  // In HOLD the address already points one word ahead so OMDR is ready at handshake.
  always_comb begin
    w_omar = BASE_ADDR;
    if (r_state == HOLD) w_omar = BASE_ADDR + w_idx_p1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_index    <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_sum      <= '0;
      r_inf      <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (i_done) begin
            r_count <= i_node_count;
            r_sum   <= '0;
            r_inf   <= '0;
            if (i_neg_cycle) begin
              r_state <= NEG;
              r_valid <= 1'b1;
              r_data  <= MARKER;
              r_index <= '1;
              r_last  <= 1'b1;
              r_busy  <= 1'b1;
            end else if (i_node_count == '0) begin
              r_state    <= FIN;
              r_finished <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_busy  <= 1'b1;
            end
          end
        end
        FETCH: begin
          r_idx   <= '0;
          r_data  <= i_omdr;
          r_index <= '0;
          r_valid <= 1'b1;
          r_last  <= (r_count == ADDR_W'(1));
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_valid && i_out_ready) begin
            if (r_data == INF) r_inf <= r_inf + ADDR_W'(1);
            else               r_sum <= r_sum + 24'(r_data);
            if (r_last) begin
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_state    <= FIN;
            end else begin
              r_idx   <= w_idx_p1;
              r_data  <= i_omdr;
              r_index <= w_idx_p1;
              r_last  <= (w_idx_p2 == r_count);
            end
          end
        end
        NEG: begin
          if (i_out_ready) begin
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_state    <= FIN;
          end
        end
        FIN: begin
          if (!i_done) begin
            r_finished <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_omar      = w_omar;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_index = r_index;
  assign o_out_last  = r_last;
  assign o_sum       = r_sum;
  assign o_inf_count = r_inf;
  assign o_busy      = r_busy;
  assign o_finished  = r_finished;

endmodule

// File: tb/tb_bf_result_streamer.sv
// tb/tb_bf_result_streamer.sv - directed self-checking bench for bf_result_streamer
module tb_bf_result_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done = 1'b0;
  logic        neg_cycle = 1'b0;
  logic [12:0] node_count = '0;
  logic [12:0] omar;
  logic [15:0] omdr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [12:0] out_index;
  logic        out_last;
  logic [23:0] sum;
  logic [12:0] inf_count;
  logic        busy;
  logic        finished;

  logic [15:0] mem [0:15];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign omdr = mem[omar[3:0]];

  bf_result_streamer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_done       (done),
    .i_neg_cycle  (neg_cycle),
    .i_node_count (node_count),
    .o_omar       (omar),
    .i_omdr       (omdr),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_index  (out_index),
    .o_out_last   (out_last),
    .o_sum        (sum),
    .o_inf_count  (inf_count),
    .o_busy       (busy),
    .o_finished   (finished)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raises Done, consumes the stream and checks every beat against mem or the marker.
  task automatic stream(input logic [12:0] n, input bit neg, input bit bp, input int exp_beats,
                        input logic [23:0] exp_sum, input logic [12:0] exp_inf, input int exp_cyc);
    int cyc;
    int beats;
    bit pend;
    bit fin_seen;
    logic [15:0] hd;
    logic [12:0] hi;
    logic hl;
    logic [15:0] ed;
    logic [12:0] ei;
    logic el;
    beats = 0; pend = 0; fin_seen = 0; hd = '0; hi = '0; hl = 1'b0;
    node_count = n; neg_cycle = neg; done = 1'b1;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      out_ready = bp ? cyc[0] : 1'b1;
      if (finished) begin
        fin_seen = 1;
        break;
      end
      check("busy_in_stream", busy, 1);
      if (cyc == 1) check("omar_fetch", omar, 0);
      if (pend && out_valid) begin
        check("hold_data", out_data, hd);
        check("hold_index", out_index, hi);
        check("hold_last", out_last, hl);
      end
      pend = 0;
      if (out_valid) begin
        if (out_ready) begin
          ed = neg ? 16'h8000 : mem[beats];
          ei = neg ? 13'h1FFF : 13'(beats);
          el = neg ? 1'b1 : (13'(beats) == n - 13'd1);
          check("beat_data", out_data, ed);
          check("beat_index", out_index, ei);
          check("beat_last", out_last, el);
          beats++;
        end else begin
          pend = 1; hd = out_data; hi = out_index; hl = out_last;
        end
      end
    end
    check("finished_reached", fin_seen, 1);
    if (exp_cyc > 0) check("finish_cycle", cyc, exp_cyc);
    check("beat_count", beats, exp_beats);
    check("sum", sum, exp_sum);
    check("inf_count", inf_count, exp_inf);
    check("busy_at_fin", busy, 0);
    check("valid_at_fin", out_valid, 0);
    done = 1'b0; neg_cycle = 1'b0;
    @(negedge clk);
    check("rearm_finished_low", finished, 0);
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_sum", sum, 0);
    check("rst_omar", omar, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal stream: 0 + 5 + 3 = 8, one INF; FIN 5 cycles after FETCH.
    mem[0] = 16'h0000; mem[1] = 16'h0005; mem[2] = 16'hFFFF; mem[3] = 16'h0003;
    stream(13'd4, 1'b0, 1'b0, 4, 24'd8, 13'd1, 6);
    stream(13'd4, 1'b0, 1'b1, 4, 24'd8, 13'd1, -1);
    stream(13'd5, 1'b1, 1'b0, 1, 24'd0, 13'd0, 2);
    stream(13'd0, 1'b0, 1'b0, 0, 24'd0, 13'd0, 1);

    // Reset in the middle of a six-word stream, then rerun it cleanly.
    for (int i = 0; i < 6; i++) mem[i] = 16'(i + 1);
    node_count = 13'd6; done = 1'b1; out_ready = 1'b1;
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 13'd2) begin
        hit = 1;
        break;
      end
    end
    check("reach_beat2", hit, 1);
    check("partial_sum", sum, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_data", out_data, 0);
    check("arst_index", out_index, 0);
    check("arst_sum", sum, 0);
    check("arst_busy", busy, 0);
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream(13'd6, 1'b0, 1'b0, 6, 24'd21, 13'd0, 8);

    // Re-arm with wide values: FFFE + FFFE = 1FFFC, FFFF counted as unreachable.
    mem[0] = 16'hFFFF; mem[1] = 16'hFFFE; mem[2] = 16'hFFFE;
    stream(13'd3, 1'b0, 1'b0, 3, 24'h01FFFC, 13'd1, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
